// File: rtl/cpu_ram_responder.sv
// CPU-side RAM responder: one-cycle registered read (write-first), memory-mapped output register,
// and a byte-serial loader that holds the CPU in reset; loader bytes are accepted only while ld_ready is high.
module cpu_ram_responder #(
  parameter int          ADDR_W  = 13,
  parameter logic [12:0] IO_ADDR = 13'h1FFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEn,
  input  logic [12:0] addr_toRAM,
  input  logic [15:0] data_toRAM,
  output logic [15:0] data_fromRAM,
  output logic [15:0] io_out,
  output logic        cpu_hold,
  input  logic        ld_start,
  input  logic [12:0] ld_count,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_LD_HI = 2'd1;
  localparam logic [1:0] ST_LD_LO = 2'd2;

  logic [15:0] mem [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [12:0] ld_addr_q, ld_addr_d;
  logic [12:0] ld_cnt_q, ld_cnt_d;
  logic [7:0]  ld_hi_q, ld_hi_d;
  logic [15:0] io_q, io_d;
  logic [15:0] rd_q, rd_d;
  logic        use_ram_q, use_ram_d;
  logic [15:0] ram_rd_q;

  logic              is_io;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdat;

  assign is_io = (addr_toRAM == IO_ADDR);

  always_comb begin
    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    ld_cnt_d  = ld_cnt_q;
    ld_hi_d   = ld_hi_q;
    io_d      = io_q;
    rd_d      = 16'h0000;
    use_ram_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr_toRAM[ADDR_W-1:0];
    mem_wdat  = data_toRAM;

    case (state_q)
      ST_RUN: begin
        // Non-RAM read sources (I/O register, write-first bypass) go through rd_q
        if (is_io) begin
          rd_d = wrEn ? data_toRAM : io_q;
          if (wrEn) io_d = data_toRAM;
        end else begin
          mem_we    = wrEn;
          rd_d      = data_toRAM;
          use_ram_d = ~wrEn;
        end
        if (ld_start && (ld_count != 13'd0)) begin
          ld_cnt_d  = ld_count;
          ld_addr_d = 13'd0;
          state_d   = ST_LD_HI;
        end
      end
      ST_LD_HI: begin
        if (ld_valid) begin
          ld_hi_d = ld_byte;
          state_d = ST_LD_LO;
        end
      end
      ST_LD_LO: begin
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_waddr = ld_addr_q[ADDR_W-1:0];
          mem_wdat  = {ld_hi_q, ld_byte};
          if (ld_addr_q == ld_cnt_q - 13'd1) begin
            state_d = ST_RUN;
          end else begin
            ld_addr_d = ld_addr_q + 13'd1;
            state_d   = ST_LD_HI;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      ld_addr_q <= 13'd0;
      ld_cnt_q  <= 13'd0;
      ld_hi_q   <= 8'h00;
      io_q      <= 16'h0000;
      rd_q      <= 16'h0000;
      use_ram_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_addr_q <= ld_addr_d;
      ld_cnt_q  <= ld_cnt_d;
      ld_hi_q   <= ld_hi_d;
      io_q      <= io_d;
      rd_q      <= rd_d;
      use_ram_q <= use_ram_d;
    end
  end

  // Block-RAM style port: contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdat;
    ram_rd_q <= mem[addr_toRAM[ADDR_W-1:0]];
  end

  assign data_fromRAM = use_ram_q ? ram_rd_q : rd_q;
  assign io_out       = io_q;
  assign cpu_hold     = (state_q != ST_RUN);
  assign ld_ready     = (state_q != ST_RUN);

endmodule

// File: tb/tb_cpu_ram_responder.sv
// Bench for cpu_ram_responder (ADDR_W=8): directed vectors, a behavioural model checked every cycle,
// and literal expectations at the key points.
module tb_cpu_ram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrEn;
  logic [12:0] addr_toRAM;
  logic [15:0] data_toRAM;
  logic [15:0] data_fromRAM;
  logic [15:0] io_out;
  logic        cpu_hold;
  logic        ld_start;
  logic [12:0] ld_count;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;

  int checks = 0;
  int errors = 0;

  cpu_ram_responder #(.ADDR_W(8), .IO_ADDR(13'h1FFF)) dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .addr_toRAM(addr_toRAM),
    .data_toRAM(data_toRAM), .data_fromRAM(data_fromRAM), .io_out(io_out),
    .cpu_hold(cpu_hold), .ld_start(ld_start), .ld_count(ld_count),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Behavioural model: word array + "loading" flag and a byte counter
  logic [15:0] m_mem [256];
  bit          m_known [256];
  logic [15:0] m_io, m_rd, m_hi;
  bit          m_rd_known, m_loading, m_live;
  int          m_words, m_bytes;

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    m_live = 1'b0;
  end

  always @(posedge clk) begin
    int idx;
    m_live = 1'b1;
    if (rst) begin
      m_rd = 16'h0; m_rd_known = 1'b1; m_io = 16'h0; m_loading = 1'b0;
    end else if (!m_loading) begin
      idx = int'(addr_toRAM) % 256;
      if (addr_toRAM == 13'h1FFF) begin
        m_rd = wrEn ? data_toRAM : m_io;
        m_rd_known = 1'b1;
        if (wrEn) m_io = data_toRAM;
      end else begin
        if (wrEn) begin m_mem[idx] = data_toRAM; m_known[idx] = 1'b1; end
        m_rd = m_mem[idx];
        m_rd_known = m_known[idx];
      end
      if (ld_start && ld_count != 0) begin
        m_loading = 1'b1; m_words = int'(ld_count); m_bytes = 0;
      end
    end else begin
      m_rd = 16'h0; m_rd_known = 1'b1;
      if (ld_valid) begin
        if (m_bytes % 2 == 0) m_hi = {8'h00, ld_byte};
        else begin
          idx = (m_bytes / 2) % 256;
          m_mem[idx] = {m_hi[7:0], ld_byte};
          m_known[idx] = 1'b1;
        end
        m_bytes++;
        if (m_bytes == 2 * m_words) m_loading = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("cyc_cpu_hold", {15'b0, cpu_hold}, {15'b0, m_loading});
      chk("cyc_ld_ready", {15'b0, ld_ready}, {15'b0, m_loading});
      chk("cyc_io_out", io_out, m_io);
      if (m_rd_known) chk("cyc_data_fromRAM", data_fromRAM, m_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic we, input logic [12:0] a, input logic [15:0] d);
    wrEn = we; addr_toRAM = a; data_toRAM = d;
    tick();
    wrEn = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_valid = 1'b1; ld_byte = b;
    tick();
    ld_valid = 1'b0;
  endtask

  logic [7:0] img [6];

  initial begin
    rst = 1'b1; wrEn = 1'b0; addr_toRAM = 13'h0; data_toRAM = 16'h0;
    ld_start = 1'b0; ld_count = 13'h0; ld_valid = 1'b0; ld_byte = 8'h0;
    img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h56;
    img[3] = 8'h78; img[4] = 8'h9A; img[5] = 8'hBC;

    tick(); tick();
    chk("rst_data_fromRAM", data_fromRAM, 16'h0000);
    chk("rst_io_out", io_out, 16'h0000);
    chk("rst_cpu_hold", {15'b0, cpu_hold}, 16'h0000);
    chk("rst_ld_ready", {15'b0, ld_ready}, 16'h0000);
    rst = 1'b0;

    cpu(1'b1, 13'h0005, 16'hBEEF);
    cpu(1'b0, 13'h0005, 16'h0000);
    chk("wr_rd_beef", data_fromRAM, 16'hBEEF);

    cpu(1'b1, 13'h0010, 16'h0000);
    cpu(1'b1, 13'h0010, 16'h1234);
    chk("write_first", data_fromRAM, 16'h1234);

    cpu(1'b1, 13'h0105, 16'h00AA);
    cpu(1'b0, 13'h0005, 16'h0000);
    chk("alias_read", data_fromRAM, 16'h00AA);

    cpu(1'b1, 13'h1FFF, 16'h5A5A);
    chk("io_write", io_out, 16'h5A5A);
    chk("io_write_first", data_fromRAM, 16'h5A5A);
    cpu(1'b0, 13'h1FFF, 16'h0000);
    chk("io_read", data_fromRAM, 16'h5A5A);

    // Loader bytes while in RUN are ignored
    addr_toRAM = 13'h0005;
    send_byte(8'hEE);
    chk("run_byte_ignored_ready", {15'b0, ld_ready}, 16'h0000);

    ld_start = 1'b1; ld_count = 13'd0;
    cpu(1'b0, 13'h0005, 16'h0000);
    ld_start = 1'b0;
    chk("zero_count_hold", {15'b0, cpu_hold}, 16'h0000);
    chk("zero_count_rd", data_fromRAM, 16'h00AA);

    // Three-word load; the start cycle also carries a CPU write
    ld_start = 1'b1; ld_count = 13'd3;
    cpu(1'b1, 13'h0020, 16'h7777);
    ld_start = 1'b0;
    chk("load_hold_rise", {15'b0, cpu_hold}, 16'h0001);
    for (int i = 0; i < 6; i++) begin
      int gap;
      gap = (i == 2) ? 1 + int'($urandom_range(0, 2)) : int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        wrEn = (i == 2); addr_toRAM = 13'h0001; data_toRAM = 16'hFFFF;
        tick();
        wrEn = 1'b0;
      end
      if (i == 5) chk("load_hold_before_last", {15'b0, cpu_hold}, 16'h0001);
      send_byte(img[i]);
      if (i == 0) chk("load_rd_zero", data_fromRAM, 16'h0000);
    end
    chk("load_hold_fall", {15'b0, cpu_hold}, 16'h0000);
    chk("load_io_kept", io_out, 16'h5A5A);

    cpu(1'b0, 13'h0000, 16'h0000); chk("load_mem0", data_fromRAM, 16'h1234);
    cpu(1'b0, 13'h0001, 16'h0000); chk("load_mem1", data_fromRAM, 16'h5678);
    cpu(1'b0, 13'h0002, 16'h0000); chk("load_mem2", data_fromRAM, 16'h9ABC);
    cpu(1'b0, 13'h0020, 16'h0000); chk("start_cycle_write", data_fromRAM, 16'h7777);

    // Abort a 4-word load after one word plus a high byte
    ld_start = 1'b1; ld_count = 13'd4;
    tick();
    ld_start = 1'b0;
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h11);
    chk("abort_hold_pre", {15'b0, cpu_hold}, 16'h0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_hold", {15'b0, cpu_hold}, 16'h0000);
    chk("abort_ready", {15'b0, ld_ready}, 16'h0000);
    chk("abort_io", io_out, 16'h0000);
    cpu(1'b0, 13'h0000, 16'h0000); chk("abort_mem0", data_fromRAM, 16'hABCD);
    cpu(1'b0, 13'h0001, 16'h0000); chk("abort_mem1", data_fromRAM, 16'h5678);

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_ram_responder.md
# cpu_ram_responder

Memory-side responder for the 16-bit accumulator CPU's single RAM port. It answers the CPU's address, write-enable and write-data with a one-cycle registered read. It also provides a memory-mapped output register and a byte-serial program loader that holds the CPU in reset while it fills RAM. It sits between the CPU and the FPGA block RAM and I/O pins.

## Interface
Parameters:
- ADDR_W, 13: implemented RAM address bits. Depth is 2^ADDR_W words of 16 bits. Lower it to fit the FPGA.
- IO_ADDR, 13'h1FFF: full 13-bit address of the output register. Takes priority over RAM.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- wrEn  input  1  CPU write strobe
- addr_toRAM  input  13  CPU address; RAM uses bits [ADDR_W-1:0]
- data_toRAM  input  16  CPU write data
- data_fromRAM  output  16  registered read data returned to the CPU
- io_out  output  16  memory-mapped output register, e.g. LEDs
- cpu_hold  output  1  high while loading; ORed externally into the CPU's rst
- ld_start  input  1  one-cycle pulse that requests a program load
- ld_count  input  13  number of 16-bit words to load; sampled at ld_start
- ld_valid  input  1  loader byte valid
- ld_byte  input  8  loader byte, high byte of each word first
- ld_ready  output  1  responder can accept a loader byte

## Operation
- FSM states: RUN, LD_HI, LD_LO. Reset state is RUN.
- RUN, CPU port:
  - Each cycle, data_fromRAM <= read value at addr_toRAM.
  - If addr_toRAM == IO_ADDR, the read value is io_out, not RAM.
  - If wrEn=1 and addr_toRAM == IO_ADDR: io_out <= data_toRAM; RAM is untouched.
  - If wrEn=1 at any other address: mem[addr_toRAM[ADDR_W-1:0]] <= data_toRAM.
  - Read-during-write to the same location is write-first: data_fromRAM takes data_toRAM. This also applies to IO_ADDR.
  - Address bits above ADDR_W are ignored for RAM, so addresses alias (wrap) modulo 2^ADDR_W.
- RUN, load request:
  - ld_start=1 with ld_count != 0: latch ld_count, clear ld_addr to 0, go to LD_HI.
  - ld_start=1 with ld_count == 0: ignored; stay in RUN.
  - CPU access in the same cycle as ld_start is still serviced.
- LD_HI: ld_ready=1. On ld_valid: capture ld_byte as the high byte, go to LD_LO.
- LD_LO: ld_ready=1. On ld_valid:
  - Write {hi, ld_byte} to mem[ld_addr].
  - If ld_addr == count-1, go to RUN. Otherwise ld_addr++ and go to LD_HI.
- In LD_HI and LD_LO:
  - cpu_hold=1.
  - CPU wrEn is ignored.
  - data_fromRAM is registered to 0.
  - io_out holds its value.
  - ld_start is ignored.
- Loader handshake: a byte transfers on a cycle where ld_valid and ld_ready are both 1. ld_valid while ld_ready=0 (RUN) is ignored.
- Reset:
  - Outputs: data_fromRAM=0, io_out=0, cpu_hold=0, ld_ready=0; state RUN; ld_addr=0.
  - RAM contents are not cleared.
  - Reset mid-load aborts the load. Words already written remain.

## Timing
- Read latency is exactly 1 cycle. An address driven in cycle N is valid on data_fromRAM after the edge ending cycle N. This matches a CPU that drives the address in one state and samples the data in the next.
- Writes take effect at the edge ending the wrEn cycle. A read of that address in the next cycle returns the new data.
- ld_ready and cpu_hold are Moore outputs, decoded from state only.
- cpu_hold rises the cycle after ld_start. It falls the cycle after the final low byte is accepted.
- Minimum load time is 2*count cycles plus 1 (the start cycle).
- The CPU sees cpu_hold low only from RUN. It then restarts from its own reset with the new image.

## Test plan
- Reset: assert rst 2 cycles -> data_fromRAM=0, io_out=0, cpu_hold=0, ld_ready=0.
- Write then read: write 16'hBEEF to 13'h0005, then read 13'h0005 -> data_fromRAM=16'hBEEF one cycle later.
- Write-first: wrEn=1, addr=13'h0010, data=16'h1234, with the prior contents 16'h0000 -> the same-cycle read returns 16'h1234.
- Aliasing and I/O, with ADDR_W=8:
  - Write 16'h00AA to 13'h0105, then read 13'h0005 -> 16'h00AA.
  - Write 16'h5A5A to 13'h1FFF -> io_out=16'h5A5A.
  - Read 13'h1FFF -> 16'h5A5A.
- Load 3 words, bytes 12 34 56 78 9A BC, with random ld_valid gaps:
  - mem[0..2] = 16'h1234, 16'h5678, 16'h9ABC.
  - cpu_hold is high throughout the load and falls 1 cycle after the last byte.
  - A wrEn pulsed during the load leaves memory unchanged.
- Abort and degenerate start:
  - ld_start with ld_count=0 -> stays in RUN, cpu_hold=0.
  - rst after 1 word of a 4-word load -> RUN, cpu_hold=0, mem[0] keeps the loaded word.
